bram_ifm_pingpong: RTL and testbench

//   Double-buffered (ping-pong) IFM feature-map store.
//   - Loader streams a frame into one bank with auto-incrementing word address.
//   - Compute datapath reads the other, already-committed bank by byte address.
//   - Bank ownership is exchanged through commit (wr_last) / release (rd_done)

---
 rtl/bram_ifm_pingpong_if.sv | 50 +++++
 rtl/bram_ifm_pingpong.sv | 156 +++++++++++++++
 tb/tb_bram_ifm_pingpong.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_ifm_pingpong_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_ifm_pingpong_if
// Description : Bus bundle for the ping-pong IFM store. It carries the
//               loader-side write stream with its commit strobe and status,
//               and the compute-side byte-addressed read port with its
//               release strobe, read data and sticky error flags.
//               slave  : the store itself (drives the o_* signals)
//               master : loader/compute side (drives the i_* signals)
// Ports       : i_wr_en, i_wr_data, i_wr_last, o_wr_ready, o_wr_count
//               i_rd_en, i_rd_addr, i_rd_done, o_rd_ready, o_rd_len
//               o_data_out, o_data_valid, o_err_ovf, o_err_addr
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_ifm_pingpong_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 17,
  parameter int RD_ADDR_WIDTH = 20
);
  // Loader side
  logic                    i_wr_en;
  logic [DATA_WIDTH-1:0]   i_wr_data;
  logic                    i_wr_last;
  logic                    o_wr_ready;
  logic [ADDR_WIDTH:0]     o_wr_count;
  // Compute side
  logic                    i_rd_en;
  logic [RD_ADDR_WIDTH-1:0] i_rd_addr;
  logic                    i_rd_done;
  logic                    o_rd_ready;
  logic [ADDR_WIDTH:0]     o_rd_len;
  logic [DATA_WIDTH-1:0]   o_data_out;
  logic                    o_data_valid;
  // Sticky errors
  logic                    o_err_ovf;
  logic                    o_err_addr;

  modport slave (
    input  i_wr_en, i_wr_data, i_wr_last, i_rd_en, i_rd_addr, i_rd_done,
    output o_wr_ready, o_wr_count, o_rd_ready, o_rd_len,
           o_data_out, o_data_valid, o_err_ovf, o_err_addr
  );

  modport master (
    output i_wr_en, i_wr_data, i_wr_last, i_rd_en, i_rd_addr, i_rd_done,
    input  o_wr_ready, o_wr_count, o_rd_ready, o_rd_len,
           o_data_out, o_data_valid, o_err_ovf, o_err_addr
  );
endinterface
`default_nettype wire

// File: rtl/bram_ifm_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : bram_ifm_pingpong
// Description : Double-buffered IFM feature-map store. The loader streams a
//               frame into the write bank (auto-incrementing word address);
//               the compute side reads the other, committed bank by byte
//               address. Banks change hands via commit (i_wr_last, or a full
//               bank) and release (i_rd_done).
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - bram_ifm_pingpong_if.slave (write stream, read port,
//                       bank status, sticky error flags)
// Options     : IFM_OUT_REG_EN - adds an output register after the memory
//               read (read latency 2 instead of 1).
// Revision    : 1.0 - initial release
// ============================================================================
module bram_ifm_pingpong #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 100352,
  parameter int ADDR_WIDTH    = 17,
  parameter int RD_ADDR_WIDTH = 20,
  parameter int RD_ADDR_SHIFT = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  bram_ifm_pingpong_if.slave    bus
);

  localparam int c_len_w = ADDR_WIDTH + 1;
  // Common width for comparing the read word address against a frame length.
  localparam int c_cmp_w = (RD_ADDR_WIDTH > c_len_w) ? RD_ADDR_WIDTH : c_len_w;
  localparam logic [c_len_w-1:0] c_last_ptr = c_len_w'(DEPTH - 1);

  logic [DATA_WIDTH-1:0]    r_mem [2][DEPTH];

  logic                     r_wr_bank;
  logic                     r_rd_bank;
  logic [1:0]               r_full;
  logic [c_len_w-1:0]       r_wr_ptr;
  logic [c_len_w-1:0]       r_len [2];
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_rvalid;
  logic                     r_err_ovf;
  logic                     r_err_addr;

  logic                     w_wr_ready;
  logic                     w_rd_ready;
  logic                     w_wr_fire;
  logic                     w_wr_drop;
  logic                     w_commit;
  logic                     w_rd_fire;
  logic                     w_release;
  logic [RD_ADDR_WIDTH-1:0] w_rd_word;
  logic                     w_rd_in_range;
  logic [1:0]               w_full_nxt;

  assign w_wr_ready    = !r_full[r_wr_bank];
  assign w_rd_ready    = r_full[r_rd_bank];
  assign w_wr_fire     = bus.i_wr_en && w_wr_ready;
  assign w_wr_drop     = bus.i_wr_en && !w_wr_ready;
  assign w_commit      = w_wr_fire && (bus.i_wr_last || (r_wr_ptr == c_last_ptr));
  assign w_rd_fire     = bus.i_rd_en && w_rd_ready;
  assign w_release     = bus.i_rd_done && w_rd_ready;
  assign w_rd_word     = bus.i_rd_addr >> RD_ADDR_SHIFT;
  assign w_rd_in_range = c_cmp_w'(w_rd_word) < c_cmp_w'(r_len[r_rd_bank]);

  // Commit needs the write bank empty and release needs the read bank full,
  // so when both fire they always touch different bits.
  always_comb begin
    w_full_nxt = r_full;
    if (w_commit)  w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // Memory array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_bank][r_wr_ptr[ADDR_WIDTH-1:0]] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_wr_ptr   <= '0;
      r_len[0]   <= '0;
      r_len[1]   <= '0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        if (w_commit) begin
          r_len[r_wr_bank] <= r_wr_ptr + 1'b1;
          r_wr_bank        <= !r_wr_bank;
          r_wr_ptr         <= '0;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
      if (w_wr_drop) r_err_ovf <= 1'b1;
      if (w_release) r_rd_bank <= !r_rd_bank;
    end
  end

  // Read port. A read issued alongside a release uses the pre-toggle bank,
  // since r_rd_bank only changes at this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_err_addr <= 1'b0;
    end else begin
      r_rvalid <= w_rd_fire;
      if (w_rd_fire) begin
        if (w_rd_in_range) begin
          r_rdata <= r_mem[r_rd_bank][w_rd_word[ADDR_WIDTH-1:0]];
        end else begin
          r_rdata    <= '0;
          r_err_addr <= 1'b1;
        end
      end
    end
  end

`ifdef IFM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_dout_q;
  logic                  r_dval_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_q <= '0;
      r_dval_q <= 1'b0;
    end else begin
      r_dout_q <= r_rdata;
      r_dval_q <= r_rvalid;
    end
  end

  assign bus.o_data_out   = r_dout_q;
  assign bus.o_data_valid = r_dval_q;
`else
  assign bus.o_data_out   = r_rdata;
  assign bus.o_data_valid = r_rvalid;
`endif

  assign bus.o_wr_ready = w_wr_ready;
  assign bus.o_rd_ready = w_rd_ready;
  assign bus.o_rd_len   = r_len[r_rd_bank];
  assign bus.o_wr_count = r_wr_ptr;
  assign bus.o_err_ovf  = r_err_ovf;
  assign bus.o_err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_bram_ifm_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_ifm_pingpong
// Description : Self-checking bench for bram_ifm_pingpong with a small bank
//               depth: reset, frame load/commit, table of reads, overflow
//               drop, release, simultaneous commit/release, auto-commit on a
//               full bank, ignored release, and asynchronous mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_ifm_pingpong;

  localparam int DW    = 32;
  localparam int DEP   = 16;
  localparam int AW    = 4;
  localparam int RAW   = 20;
`ifdef IFM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  bram_ifm_pingpong_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_ADDR_WIDTH(RAW)) bus ();

  bram_ifm_pingpong #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW),
    .RD_ADDR_WIDTH(RAW), .RD_ADDR_SHIFT(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [RAW-1:0] addr;
    logic [DW-1:0]  data;
    logic           err;
  } rd_vec_t;

  rd_vec_t vec [9];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic last);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_data = d;
    bus.i_wr_last = last;
    step();
    bus.i_wr_en   = 1'b0;
    bus.i_wr_last = 1'b0;
  endtask

  task automatic rd(input logic [RAW-1:0] a);
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = a;
    step();
    bus.i_rd_en   = 1'b0;
    repeat (LAT - 1) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " data_out"},   bus.o_data_out, 32'h0);
    chk({tag, " data_valid"}, {31'b0, bus.o_data_valid}, 32'h0);
    chk({tag, " err_ovf"},    {31'b0, bus.o_err_ovf}, 32'h0);
    chk({tag, " err_addr"},   {31'b0, bus.o_err_addr}, 32'h0);
    chk({tag, " wr_count"},   32'(bus.o_wr_count), 32'h0);
    chk({tag, " rd_len"},     32'(bus.o_rd_len), 32'h0);
    chk({tag, " wr_ready"},   {31'b0, bus.o_wr_ready}, 32'h1);
    chk({tag, " rd_ready"},   {31'b0, bus.o_rd_ready}, 32'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    // Reads of frame A = {11,22,33,44}; byte addresses, low 2 bits ignored.
    vec[0] = '{addr: 20'h00000, data: 32'h11, err: 1'b0};
    vec[1] = '{addr: 20'h00004, data: 32'h22, err: 1'b0};
    vec[2] = '{addr: 20'h00008, data: 32'h33, err: 1'b0};
    vec[3] = '{addr: 20'h0000C, data: 32'h44, err: 1'b0};
    vec[4] = '{addr: 20'h0000F, data: 32'h44, err: 1'b0};
    vec[5] = '{addr: 20'h00010, data: 32'h00, err: 1'b1};
    vec[6] = '{addr: 20'h0003C, data: 32'h00, err: 1'b1};
    vec[7] = '{addr: 20'hFFFFF, data: 32'h00, err: 1'b1};
    vec[8] = '{addr: 20'h00005, data: 32'h22, err: 1'b1};

    bus.i_wr_en   = 1'b0;
    bus.i_wr_data = '0;
    bus.i_wr_last = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_rd_addr = '0;
    bus.i_rd_done = 1'b0;
    rst_n         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Read with no committed frame is ignored.
    bus.i_rd_en = 1'b1;
    repeat (LAT) step();
    bus.i_rd_en = 1'b0;
    chk("rd_not_ready valid", {31'b0, bus.o_data_valid}, 32'h0);
    chk("rd_not_ready err",   {31'b0, bus.o_err_addr}, 32'h0);

    // Frame A into bank 0.
    wr(32'h11, 1'b0);
    wr(32'h22, 1'b0);
    chk("A mid wr_count", 32'(bus.o_wr_count), 32'd2);
    chk("A mid rd_ready", {31'b0, bus.o_rd_ready}, 32'h0);
    wr(32'h33, 1'b0);
    wr(32'h44, 1'b1);
    chk("A rd_ready", {31'b0, bus.o_rd_ready}, 32'h1);
    chk("A rd_len",   32'(bus.o_rd_len), 32'd4);
    chk("A wr_count", 32'(bus.o_wr_count), 32'd0);
    chk("A wr_ready", {31'b0, bus.o_wr_ready}, 32'h1);

    for (int i = 0; i < 9; i++) begin
      rd(vec[i].addr);
      chk($sformatf("vec%0d valid", i), {31'b0, bus.o_data_valid}, 32'h1);
      chk($sformatf("vec%0d data", i),  bus.o_data_out, vec[i].data);
      chk($sformatf("vec%0d err_addr", i), {31'b0, bus.o_err_addr}, {31'b0, vec[i].err});
    end
    step();
    chk("idle valid", {31'b0, bus.o_data_valid}, 32'h0);
    chk("idle hold",  bus.o_data_out, 32'h22);

    // Frame B into bank 1; both banks now full.
    wr(32'hB0, 1'b0);
    wr(32'hB1, 1'b0);
    wr(32'hB2, 1'b1);
    chk("AB wr_ready", {31'b0, bus.o_wr_ready}, 32'h0);
    chk("AB err_ovf before", {31'b0, bus.o_err_ovf}, 32'h0);
    wr(32'hDEAD, 1'b1);
    chk("drop err_ovf",  {31'b0, bus.o_err_ovf}, 32'h1);
    chk("drop wr_count", 32'(bus.o_wr_count), 32'd0);
    chk("drop rd_len",   32'(bus.o_rd_len), 32'd4);

    bus.i_rd_done = 1'b1;
    step();
    bus.i_rd_done = 1'b0;
    chk("relA wr_ready", {31'b0, bus.o_wr_ready}, 32'h1);
    chk("relA rd_ready", {31'b0, bus.o_rd_ready}, 32'h1);
    chk("relA rd_len",   32'(bus.o_rd_len), 32'd3);
    rd(20'h8);
    chk("B read", bus.o_data_out, 32'hB2);

    // Frame C into bank 0; its commit coincides with release of B and a read.
    wr(32'hC0, 1'b0);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_data = 32'hC1;
    bus.i_wr_last = 1'b1;
    bus.i_rd_done = 1'b1;
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = 20'h4;
    step();
    bus.i_wr_en   = 1'b0;
    bus.i_wr_last = 1'b0;
    bus.i_rd_done = 1'b0;
    bus.i_rd_en   = 1'b0;
    chk("both rd_ready", {31'b0, bus.o_rd_ready}, 32'h1);
    chk("both rd_len",   32'(bus.o_rd_len), 32'd2);
    chk("both wr_ready", {31'b0, bus.o_wr_ready}, 32'h1);
    chk("both wr_count", 32'(bus.o_wr_count), 32'd0);
    repeat (LAT - 1) step();
    chk("both read pre-toggle", bus.o_data_out, 32'hB1);
    chk("both read valid", {31'b0, bus.o_data_valid}, 32'h1);
    rd(20'h4);
    chk("C read", bus.o_data_out, 32'hC1);

    bus.i_rd_done = 1'b1;
    step();
    bus.i_rd_done = 1'b0;
    chk("relC rd_ready", {31'b0, bus.o_rd_ready}, 32'h0);
    chk("relC rd_len",   32'(bus.o_rd_len), 32'd3);
    // Release with nothing committed must not move the read bank.
    bus.i_rd_done = 1'b1;
    step();
    bus.i_rd_done = 1'b0;

    // Full bank (bank 1) with no i_wr_last auto-commits.
    for (int i = 0; i < DEP; i++) begin
      wr(32'h100 + 32'(i), 1'b0);
      if (i == DEP - 2) chk("auto wr_count", 32'(bus.o_wr_count), 32'(DEP - 1));
    end
    chk("auto rd_ready", {31'b0, bus.o_rd_ready}, 32'h1);
    chk("auto rd_len",   32'(bus.o_rd_len), 32'(DEP));
    chk("auto wr_count0", 32'(bus.o_wr_count), 32'd0);
    chk("auto wr_ready", {31'b0, bus.o_wr_ready}, 32'h1);
    rd(20'h3C);
    chk("auto last word", bus.o_data_out, 32'h10F);
    chk("auto err sticky", {31'b0, bus.o_err_addr}, 32'h1);

    // Partial frame in bank 0, then asynchronous reset between clock edges.
    wr(32'hE0, 1'b0);
    wr(32'hE1, 1'b0);
    wr(32'hE2, 1'b0);
    chk("pre-rst wr_count", 32'(bus.o_wr_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async rst");
    step();
    rst_n = 1'b1;
    step();

    wr(32'h77, 1'b1);
    chk("post-rst rd_ready", {31'b0, bus.o_rd_ready}, 32'h1);
    chk("post-rst rd_len",   32'(bus.o_rd_len), 32'd1);
    rd(20'h0);
    chk("post-rst read", bus.o_data_out, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
